sqrt_batch_sequencer: RTL and testbench

Upstream driver for the `squareRoot` unit. It holds a batch of 8-bit operands and launches each one through the unit using its `st`/`done` four-phase handshake. It captures each 4-bit root into a result buffer and checks every root arithmetically. Software loads operands, pulses `go`, and reads results and the mismatch count once `batch_done` fires.

---
 rtl/sqrt_seq_pkg.sv | 19 +
 rtl/sqrt_result_check.sv | 31 +++
 rtl/sqrt_batch_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_sqrt_batch_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_seq_pkg.sv
// Shared definitions for the square-root batch sequencer: the controller
// state encoding and the default geometry of the operand/result buffers.
package sqrt_seq_pkg;

    localparam int DEF_DEPTH   = 16;
    localparam int DEF_W       = 8;
    localparam int DEF_RW      = 4;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ASSERT  = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        FINISH  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/sqrt_result_check.sv
// Combinational root check: r is the integer square root of n exactly when
// r*r <= n < (r+1)*(r+1). Squares are formed one bit wider than 2*RW because
// r+1 can equal 2**RW.
module sqrt_result_check #(
    parameter int W  = 8,
    parameter int RW = 4
) (
    input  logic [W-1:0]  n_i,
    input  logic [RW-1:0] r_i,
    output logic          ok_o
);

    localparam int CW = 2 * RW + 1;

    logic [CW-1:0] r_ext;
    logic [CW-1:0] r1_ext;
    logic [CW-1:0] lo_sq;
    logic [CW-1:0] hi_sq;
    logic [CW-1:0] n_ext;

    // Bracket n between the square of r and the square of r+1.
    always_comb begin
        r_ext  = CW'(r_i);
        r1_ext = r_ext + CW'(1);
        lo_sq  = r_ext * r_ext;
        hi_sq  = r1_ext * r1_ext;
        n_ext  = CW'(n_i);
        ok_o   = (lo_sq <= n_ext) && (n_ext < hi_sq);
    end

endmodule

// File: rtl/sqrt_batch_sequencer.sv
// Batch driver for the squareRoot unit: walks the operand buffer, runs each
// operand through the unit's st/done four-phase handshake, stores every root
// in the result buffer and counts roots that fail the arithmetic check.
// Any handshake phase that stalls for TIMEOUT cycles aborts the batch.
module sqrt_batch_sequencer
    import sqrt_seq_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int W       = DEF_W,
    parameter int RW      = DEF_RW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic                     go,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [RW-1:0]            rd_data,
    output logic                     busy,
    output logic                     batch_done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   mismatch_cnt,
    output logic                     sq_st,
    output logic [W-1:0]             sq_n,
    input  logic                     sq_done,
    input  logic [RW-1:0]            sq_sqrt
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    seq_state_e state_q, state_d;

    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          sq_st_q, sq_st_d;
    logic [W-1:0]  sq_n_q, sq_n_d;
    logic          err_q, err_d;
    logic [AW:0]   mcnt_q, mcnt_d;
    logic [RW-1:0] rd_data_q;

    logic [W-1:0]  op_mem  [DEPTH];
    logic [RW-1:0] res_mem [DEPTH];

    logic          op_we;
    logic          res_we;
    logic [RW-1:0] res_wdata;
    logic          root_ok;
    logic          tmo_hit;

    sqrt_result_check #(
        .W  (W),
        .RW (RW)
    ) u_check (
        .n_i  (sq_n_q),
        .r_i  (sq_sqrt),
        .ok_o (root_ok)
    );

    // The current handshake phase has used up its cycle budget.
    assign tmo_hit = (tmo_q == TMO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update from the same pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: walk LOAD/ASSERT/WAIT_HI/WAIT_LO per entry, bail to
    // FINISH on a stalled phase.
    always_comb begin
        // NOTE: the default assignment up front keeps this block purely
        // combinational; a path that skips state_d would infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = LOAD;
            LOAD:    state_d = ASSERT;
            ASSERT:  state_d = WAIT_HI;
            WAIT_HI: begin
                if (sq_done)      state_d = WAIT_LO;
                else if (tmo_hit) state_d = FINISH;
            end
            WAIT_LO: begin
                if (!sq_done)     state_d = (idx_q == LAST_IDX) ? FINISH : LOAD;
                else if (tmo_hit) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand launch, handshake, timeout and checking.
    always_comb begin
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        sq_st_d   = sq_st_q;
        sq_n_d    = sq_n_q;
        err_d     = err_q;
        mcnt_d    = mcnt_q;
        op_we     = 1'b0;
        res_we    = 1'b0;
        res_wdata = '0;
        unique case (state_q)
            IDLE: begin
                op_we = wr_en;
                if (go) begin
                    err_d  = 1'b0;
                    mcnt_d = '0;
                    idx_d  = '0;
                end
            end
            LOAD: begin
                sq_n_d = op_mem[idx_q];
            end
            ASSERT: begin
                sq_st_d = 1'b1;
                tmo_d   = '0;
            end
            WAIT_HI: begin
                if (sq_done) begin
                    res_we    = 1'b1;
                    res_wdata = sq_sqrt;
                    sq_st_d   = 1'b0;
                    tmo_d     = '0;
                    if (!root_ok) mcnt_d = mcnt_q + (AW + 1)'(1);
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    sq_st_d = 1'b0;
                    res_we  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_LO: begin
                if (!sq_done) begin
                    if (idx_q != LAST_IDX) idx_d = idx_q + AW'(1);
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    sq_st_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            tmo_q   <= '0;
            sq_st_q <= 1'b0;
            sq_n_q  <= '0;
            err_q   <= 1'b0;
            mcnt_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            sq_st_q <= sq_st_d;
            sq_n_q  <= sq_n_d;
            err_q   <= err_d;
            mcnt_q  <= mcnt_d;
        end
    end

    // Operand and result buffers plus the registered read port.
    always_ff @(posedge clk) begin
        // NOTE: both buffers are cleared by reset, which keeps them as
        // flip-flop arrays; a RAM macro could not be reset this way.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_mem[i]  <= '0;
                res_mem[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (op_we)  op_mem[wr_addr] <= wr_data;
            if (res_we) res_mem[idx_q]  <= res_wdata;
            rd_data_q <= res_mem[rd_addr];
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy       = (state_q != IDLE);
        batch_done = (state_q == FINISH);
    end

    assign rd_data      = rd_data_q;
    assign err          = err_q;
    assign mismatch_cnt = mcnt_q;
    assign sq_st        = sq_st_q;
    assign sq_n         = sq_n_q;

endmodule

// File: tb/tb_sqrt_batch_sequencer.sv
// Directed bench for sqrt_batch_sequencer, driven by a behavioural squareRoot
// model with adjustable done latency, done hold time, a wrong-root fault and a
// never-done mode. Expected roots are hand-computed constants.
module tb_sqrt_batch_sequencer;

    localparam int DEPTH = 16;
    localparam int W     = 8;
    localparam int RW    = 4;
    localparam int AW    = 4;
    localparam int TMO   = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          go;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;
    logic          busy;
    logic          batch_done;
    logic          err;
    logic [AW:0]   mismatch_cnt;
    logic          sq_st;
    logic [W-1:0]  sq_n;
    logic          sq_done;
    logic [RW-1:0] sq_sqrt;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0]  ops      [DEPTH] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd8, 8'd9, 8'd15,
                                        8'd16, 8'd24, 8'd25, 8'd99, 8'd100, 8'd224, 8'd225, 8'd255};
    logic [RW-1:0] exp_root [DEPTH] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3,
                                        4'd4, 4'd4, 4'd5, 4'd9, 4'd10, 4'd14, 4'd15, 4'd15};
    logic [RW-1:0] got      [DEPTH];

    always #5 clk = ~clk;

    sqrt_batch_sequencer #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .go           (go),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .batch_done   (batch_done),
        .err          (err),
        .mismatch_cnt (mismatch_cnt),
        .sq_st        (sq_st),
        .sq_n         (sq_n),
        .sq_done      (sq_done),
        .sq_sqrt      (sq_sqrt)
    );

    // ---------------- behavioural squareRoot unit ----------------
    int   lat        = 5;
    int   hold       = 0;
    bit   never_done = 1'b0;
    bit   wrong_en   = 1'b0;
    logic          m_done;
    logic [RW-1:0] m_root;
    int            m_cnt;

    assign sq_done = m_done;
    assign sq_sqrt = m_root;

    function automatic logic [RW-1:0] isqrt(input logic [W-1:0] n);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(n)) r++;
        return RW'(r);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_root <= '0;
        end else if (!m_done) begin
            if (sq_st && !never_done) begin
                if (m_cnt >= lat - 1) begin
                    m_done <= 1'b1;
                    m_cnt  <= 0;
                    m_root <= (wrong_en && sq_n == 8'd100) ? 4'd7 : isqrt(sq_n);
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                m_cnt <= 0;
            end
        end else if (!sq_st) begin
            if (m_cnt >= hold) begin
                m_done <= 1'b0;
                m_cnt  <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- handshake monitor (samples on falling edge) ----------------
    bit   mon_clr = 1'b0;
    int   cyc, bd_count, st_rises, hs_viol, gap_min, gap_max, st_run, last_run, fall_cyc;
    bit   have_fall, pend;
    logic prev_st, prev_done;
    logic [W-1:0] prev_n;

    always @(negedge clk) begin
        if (mon_clr) begin
            cyc = 0; bd_count = 0; st_rises = 0; hs_viol = 0;
            gap_min = 1000; gap_max = 0; st_run = 0; last_run = 0;
            fall_cyc = 0; have_fall = 1'b0; pend = 1'b0;
        end else begin
            cyc++;
            if (batch_done) bd_count++;
            // sq_st must be low one edge after done was first seen high
            if (pend && sq_st) hs_viol++;
            pend = sq_st && sq_done && !prev_done;
            // sq_n must not move while sq_st is high, nor on the cycle before it rises
            if (sq_st && sq_n !== prev_n) hs_viol++;
            if (prev_done && !sq_done) begin
                fall_cyc  = cyc;
                have_fall = 1'b1;
            end
            if (sq_st && !prev_st) begin
                st_rises++;
                if (have_fall) begin
                    if (cyc - fall_cyc < gap_min) gap_min = cyc - fall_cyc;
                    if (cyc - fall_cyc > gap_max) gap_max = cyc - fall_cyc;
                    have_fall = 1'b0;
                end
            end
            if (sq_st) begin
                st_run++;
            end else begin
                if (prev_st) last_run = st_run;
                st_run = 0;
            end
        end
        prev_st   = sq_st;
        prev_n    = sq_n;
        prev_done = sq_done;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic write_op(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = W'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < DEPTH; i++) write_op(i, int'(ops[i]));
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic read_res(input int a, output logic [RW-1:0] v);
        rd_addr = AW'(a);
        tick();
        v = rd_data;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) read_res(i, got[i]);
    endtask

    task automatic wait_batch(input int budget, input string name);
        int n = 0;
        while (!batch_done && n < budget) begin
            tick();
            n++;
        end
        compared++;
        if (!batch_done) begin
            mismatched++;
            $display("FAIL %s batch_done: got none, want a pulse within %0d cycles", name, budget);
        end else begin
            tick();
        end
    endtask

    task automatic wait_rises(input int target, input int budget, input string name);
        int n = 0;
        while (st_rises < target && n < budget) begin
            tick();
            n++;
        end
        compared++;
        if (st_rises < target) begin
            mismatched++;
            $display("FAIL %s sq_st rises: got %0d, want %0d", name, st_rises, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        compared++; if (busy !== 1'b0)         begin mismatched++; $display("FAIL reset busy: got %0b want 0", busy); end
        compared++; if (batch_done !== 1'b0)   begin mismatched++; $display("FAIL reset batch_done: got %0b want 0", batch_done); end
        compared++; if (err !== 1'b0)          begin mismatched++; $display("FAIL reset err: got %0b want 0", err); end
        compared++; if (mismatch_cnt !== '0)   begin mismatched++; $display("FAIL reset mismatch_cnt: got %0d want 0", mismatch_cnt); end
        compared++; if (sq_st !== 1'b0)        begin mismatched++; $display("FAIL reset sq_st: got %0b want 0", sq_st); end
        compared++; if (sq_n !== '0)           begin mismatched++; $display("FAIL reset sq_n: got %0d want 0", sq_n); end
        compared++; if (rd_data !== '0)        begin mismatched++; $display("FAIL reset rd_data: got %0d want 0", rd_data); end
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            compared++;
            if (got[i] !== '0) begin mismatched++; $display("FAIL reset res[%0d]: got %0d want 0", i, got[i]); end
        end
    endtask

    task automatic test_full_batch();
        load_all();
        clear_mon();
        pulse_go();
        // LOAD cycle now; ASSERT next; sq_st visible the cycle after
        tick();
        compared++; if (sq_st !== 1'b0) begin mismatched++; $display("FAIL full st_early: got %0b want 0", sq_st); end
        tick();
        compared++; if (sq_st !== 1'b1) begin mismatched++; $display("FAIL full st_rise: got %0b want 1", sq_st); end
        wait_batch(600, "full");
        compared++; if (busy !== 1'b0)       begin mismatched++; $display("FAIL full busy: got %0b want 0", busy); end
        compared++; if (bd_count !== 1)      begin mismatched++; $display("FAIL full batch_done count: got %0d want 1", bd_count); end
        compared++; if (err !== 1'b0)        begin mismatched++; $display("FAIL full err: got %0b want 0", err); end
        compared++; if (mismatch_cnt !== '0) begin mismatched++; $display("FAIL full mismatch_cnt: got %0d want 0", mismatch_cnt); end
        compared++; if (hs_viol !== 0)       begin mismatched++; $display("FAIL full handshake violations: got %0d want 0", hs_viol); end
        compared++; if (st_rises !== DEPTH)  begin mismatched++; $display("FAIL full sq_st rises: got %0d want %0d", st_rises, DEPTH); end
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            compared++;
            if (got[i] !== exp_root[i]) begin mismatched++; $display("FAIL full res[%0d]: got %0d want %0d", i, got[i], exp_root[i]); end
        end
    endtask

    task automatic test_wrong_root();
        logic [RW-1:0] want;
        wrong_en = 1'b1;
        clear_mon();
        pulse_go();
        wait_batch(600, "wrong");
        wrong_en = 1'b0;
        compared++; if (mismatch_cnt !== 5'd1) begin mismatched++; $display("FAIL wrong mismatch_cnt: got %0d want 1", mismatch_cnt); end
        compared++; if (err !== 1'b0)          begin mismatched++; $display("FAIL wrong err: got %0b want 0", err); end
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            want = (i == 12) ? 4'd7 : exp_root[i];
            compared++;
            if (got[i] !== want) begin mismatched++; $display("FAIL wrong res[%0d]: got %0d want %0d", i, got[i], want); end
        end
    endtask

    task automatic test_handshake();
        logic [RW-1:0] v;
        hold = 3;
        clear_mon();
        pulse_go();
        wait_batch(800, "hs");
        hold = 0;
        compared++; if (hs_viol !== 0)       begin mismatched++; $display("FAIL hs violations: got %0d want 0", hs_viol); end
        compared++; if (gap_min !== 3)       begin mismatched++; $display("FAIL hs min done-low to st-rise: got %0d want 3", gap_min); end
        compared++; if (gap_max !== 3)       begin mismatched++; $display("FAIL hs max done-low to st-rise: got %0d want 3", gap_max); end
        compared++; if (mismatch_cnt !== '0) begin mismatched++; $display("FAIL hs mismatch_cnt: got %0d want 0", mismatch_cnt); end
        read_res(12, v);
        compared++; if (v !== 4'd10)         begin mismatched++; $display("FAIL hs res[12]: got %0d want 10", v); end
    endtask

    task automatic test_timeout();
        logic [RW-1:0] v;
        never_done = 1'b1;
        clear_mon();
        pulse_go();
        wait_batch(200, "tmo");
        compared++; if (err !== 1'b1)        begin mismatched++; $display("FAIL tmo err: got %0b want 1", err); end
        compared++; if (last_run !== TMO)    begin mismatched++; $display("FAIL tmo sq_st high cycles: got %0d want %0d", last_run, TMO); end
        compared++; if (busy !== 1'b0)       begin mismatched++; $display("FAIL tmo busy: got %0b want 0", busy); end
        compared++; if (bd_count !== 1)      begin mismatched++; $display("FAIL tmo batch_done count: got %0d want 1", bd_count); end
        compared++; if (st_rises !== 1)      begin mismatched++; $display("FAIL tmo sq_st rises: got %0d want 1", st_rises); end
        compared++; if (mismatch_cnt !== '0) begin mismatched++; $display("FAIL tmo mismatch_cnt: got %0d want 0", mismatch_cnt); end
        read_res(0, v);
        compared++; if (v !== 4'd0)          begin mismatched++; $display("FAIL tmo res[0]: got %0d want 0", v); end
        read_res(1, v);
        compared++; if (v !== 4'd1)          begin mismatched++; $display("FAIL tmo res[1]: got %0d want 1", v); end
        never_done = 1'b0;
        clear_mon();
        pulse_go();
        compared++; if (err !== 1'b0)        begin mismatched++; $display("FAIL tmo err after go: got %0b want 0", err); end
        wait_batch(600, "tmo_rerun");
        compared++; if (err !== 1'b0)        begin mismatched++; $display("FAIL tmo err after rerun: got %0b want 0", err); end
        compared++; if (bd_count !== 1)      begin mismatched++; $display("FAIL tmo rerun batch_done count: got %0d want 1", bd_count); end
    endtask

    task automatic test_reset_mid();
        logic [RW-1:0] v;
        clear_mon();
        pulse_go();
        wait_rises(6, 300, "rstmid");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++; if (busy !== 1'b0)       begin mismatched++; $display("FAIL rstmid busy: got %0b want 0", busy); end
        compared++; if (sq_st !== 1'b0)      begin mismatched++; $display("FAIL rstmid sq_st: got %0b want 0", sq_st); end
        compared++; if (rd_data !== '0)      begin mismatched++; $display("FAIL rstmid rd_data: got %0d want 0", rd_data); end
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            compared++;
            if (got[i] !== '0) begin mismatched++; $display("FAIL rstmid res[%0d]: got %0d want 0", i, got[i]); end
        end
        load_all();
        write_op(0, 49);
        clear_mon();
        pulse_go();
        tick();
        tick();
        compared++; if (sq_st !== 1'b1)      begin mismatched++; $display("FAIL rstmid restart sq_st: got %0b want 1", sq_st); end
        compared++; if (sq_n !== 8'd49)      begin mismatched++; $display("FAIL rstmid restart sq_n: got %0d want 49", sq_n); end
        wait_batch(600, "rstmid_rerun");
        compared++; if (st_rises !== DEPTH)  begin mismatched++; $display("FAIL rstmid sq_st rises: got %0d want %0d", st_rises, DEPTH); end
        read_res(0, v);
        compared++; if (v !== 4'd7)          begin mismatched++; $display("FAIL rstmid res[0]: got %0d want 7", v); end
        read_res(15, v);
        compared++; if (v !== 4'd15)         begin mismatched++; $display("FAIL rstmid res[15]: got %0d want 15", v); end
    endtask

    task automatic test_ignored();
        logic [RW-1:0] v;
        clear_mon();
        // write and go in the same IDLE cycle: the batch must see 144
        go      = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 8'd144;
        tick();
        go      = 1'b0;
        wr_en   = 1'b0;
        wait_rises(1, 20, "ign");
        write_op(15, 200);
        pulse_go();
        wait_batch(600, "ign");
        compared++; if (bd_count !== 1)      begin mismatched++; $display("FAIL ign batch_done count: got %0d want 1", bd_count); end
        compared++; if (st_rises !== DEPTH)  begin mismatched++; $display("FAIL ign sq_st rises: got %0d want %0d", st_rises, DEPTH); end
        compared++; if (mismatch_cnt !== '0) begin mismatched++; $display("FAIL ign mismatch_cnt: got %0d want 0", mismatch_cnt); end
        read_res(1, v);
        compared++; if (v !== 4'd12)         begin mismatched++; $display("FAIL ign res[1]: got %0d want 12", v); end
        read_res(15, v);
        compared++; if (v !== 4'd15)         begin mismatched++; $display("FAIL ign res[15]: got %0d want 15", v); end
        read_res(0, v);
        compared++; if (v !== 4'd7)          begin mismatched++; $display("FAIL ign res[0]: got %0d want 7", v); end
        // same-cycle operand write and result read of one address in IDLE
        rd_addr = 4'd1;
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 8'd0;
        tick();
        wr_en   = 1'b0;
        compared++; if (rd_data !== 4'd12)   begin mismatched++; $display("FAIL ign same-cycle read: got %0d want 12", rd_data); end
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        go      = 1'b0;
        rd_addr = '0;
        test_reset();
        test_full_batch();
        test_wrong_root();
        test_handshake();
        test_timeout();
        test_reset_mid();
        test_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
